// File: rtl/cordic_vector_synth.sv
// Rotation-mode CORDIC that regenerates (cx, cy) = amp * (cos, sin) of a first-quadrant
// angle, then folds the result into the requested quadrant with symmetric saturation.
module cordic_vector_synth #(
   parameter int ITER  = 14,
   parameter int IW    = 20,
   parameter int KGAIN = 39797
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] amp_in,
   input  logic [16:0] theta_1st_quad,
   input  logic [1:0]  quadrant,
   input  logic        angle_valid,
   output logic [15:0] cx_out,
   output logic [15:0] cy_out,
   output logic        vec_valid,
   output logic        busy,
   output logic        overrun
);

   // Handshake: angle_valid is a one-cycle strobe accepted only in IDLE; a strobe while
   // busy is dropped and flagged by a one-cycle overrun pulse. vec_valid pulses for one
   // cycle when cx_out/cy_out are updated; the outputs then hold until the next result.

   localparam int ZW = 18;
   localparam logic signed [IW-1:0] SAT_P = IW'(32767);
   localparam logic signed [IW-1:0] SAT_N = -SAT_P;

   typedef enum logic [1:0] {IDLE, SCALE, ROT, MAP} state_t;
   state_t state, state_nxt;

   logic [14:0]          amp_r;
   logic signed [16:0]   theta_r;
   logic [1:0]           quad_r;
   logic signed [IW-1:0] x_r, y_r;
   logic signed [ZW-1:0] z_r;
   logic [3:0]           i_r;

   logic signed [16:0]   theta_s, theta_clamped;
   logic signed [IW-1:0] xs, ys, x_rot, y_rot, mx, my;
   logic signed [ZW-1:0] z_rot;
   logic                 unused_amp_msb;

   assign unused_amp_msb = amp_in[15];
   assign busy           = (state != IDLE);

   function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    atan_lut = 18'sd12868;
         4'd1:    atan_lut = 18'sd7596;
         4'd2:    atan_lut = 18'sd4014;
         4'd3:    atan_lut = 18'sd2037;
         4'd4:    atan_lut = 18'sd1023;
         4'd5:    atan_lut = 18'sd512;
         4'd6:    atan_lut = 18'sd256;
         4'd7:    atan_lut = 18'sd128;
         4'd8:    atan_lut = 18'sd64;
         4'd9:    atan_lut = 18'sd32;
         4'd10:   atan_lut = 18'sd16;
         4'd11:   atan_lut = 18'sd8;
         4'd12:   atan_lut = 18'sd4;
         4'd13:   atan_lut = 18'sd2;
         default: atan_lut = 18'sd0;
      endcase
   endfunction

   // Symmetric limit keeps -32768 out so negating a result never wraps.
   function automatic logic [15:0] sat16(input logic signed [IW-1:0] v);
      if (v > SAT_P)      sat16 = 16'h7FFF;
      else if (v < SAT_N) sat16 = 16'h8001;
      else                sat16 = v[15:0];
   endfunction

   always_comb begin
      theta_s       = theta_1st_quad;
      theta_clamped = theta_s;
      if (theta_s < 17'sd0)          theta_clamped = 17'sd0;
      else if (theta_s > 17'sd25736) theta_clamped = 17'sd25736;
   end

   always_comb begin
      xs    = x_r >>> i_r;
      ys    = y_r >>> i_r;
      x_rot = x_r - ys;
      y_rot = y_r + xs;
      z_rot = z_r - atan_lut(i_r);
      if (z_r[ZW-1]) begin
         x_rot = x_r + ys;
         y_rot = y_r - xs;
         z_rot = z_r + atan_lut(i_r);
      end
   end

   always_comb begin
      mx = x_r;
      my = y_r;
      case (quad_r)
         2'd1:    begin mx = -y_r; my = x_r;  end
         2'd2:    begin mx = -x_r; my = -y_r; end
         2'd3:    begin mx = y_r;  my = -x_r; end
         default: begin mx = x_r;  my = y_r;  end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (angle_valid) state_nxt = SCALE;
         SCALE:   state_nxt = ROT;
         ROT:     if (i_r == 4'(ITER - 1)) state_nxt = MAP;
         MAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         amp_r     <= '0;
         theta_r   <= '0;
         quad_r    <= '0;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         i_r       <= '0;
         cx_out    <= '0;
         cy_out    <= '0;
         vec_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         vec_valid <= 1'b0;
         overrun   <= angle_valid && (state != IDLE);
         case (state)
            IDLE: begin
               if (angle_valid) begin
                  amp_r   <= amp_in[14:0];
                  theta_r <= theta_clamped;
                  quad_r  <= quadrant;
               end
            end
            SCALE: begin
               // Pre-scaling by 1/K cancels the CORDIC gain so |(x, y)| ends near amp.
               x_r <= $signed(IW'(({17'd0, amp_r} * 32'(KGAIN)) >> 16));
               y_r <= '0;
               z_r <= {theta_r[16], theta_r};
               i_r <= '0;
            end
            ROT: begin
               x_r <= x_rot;
               y_r <= y_rot;
               z_r <= z_rot;
               i_r <= i_r + 4'd1;
            end
            MAP: begin
               cx_out    <= sat16(mx);
               cy_out    <= sat16(my);
               vec_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector_synth.sv
// Directed bench for cordic_vector_synth: latency, quadrant folding, clamp/saturation,
// overrun, back-to-back acceptance, mid-conversion reset and zero amplitude.
module tb_cordic_vector_synth;

   logic        clk;
   logic        rst;
   logic [15:0] amp_in;
   logic [16:0] theta_1st_quad;
   logic [1:0]  quadrant;
   logic        angle_valid;
   logic [15:0] cx_out;
   logic [15:0] cy_out;
   logic        vec_valid;
   logic        busy;
   logic        overrun;

   int n_checks = 0;
   int n_errors = 0;
   int vv_cnt   = 0;
   int ov_cnt   = 0;

   cordic_vector_synth dut (
      .clk            (clk),
      .rst            (rst),
      .amp_in         (amp_in),
      .theta_1st_quad (theta_1st_quad),
      .quadrant       (quadrant),
      .angle_valid    (angle_valid),
      .cx_out         (cx_out),
      .cy_out         (cy_out),
      .vec_valid      (vec_valid),
      .busy           (busy),
      .overrun        (overrun)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (vec_valid) vv_cnt++;
      if (overrun)   ov_cnt++;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic int sx(input logic [15:0] v);
      logic signed [15:0] s;
      s = v;
      return int'(s);
   endfunction

   task automatic check(input string tag, input int actual, input int expected, input int tol);
      n_checks++;
      if ((actual - expected > tol) || (expected - actual > tol)) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, actual, expected, tol);
      end
   endtask

   // driver tasks: called at a negedge; strobe returns at the negedge after the sampling edge
   task automatic strobe(input logic [15:0] a, input int th, input logic [1:0] q);
      amp_in         = a;
      theta_1st_quad = 17'(th);
      quadrant       = q;
      angle_valid    = 1'b1;
      @(negedge clk);
      angle_valid    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns edges since the sampling edge when vec_valid is seen (60 = gave up).
   task automatic wait_vec(input int k0, output int lat, output int busy_n);
      lat    = k0;
      busy_n = 0;
      while (!vec_valid && lat < 60) begin
         if (busy) busy_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic convert(input string tag, input logic [15:0] a, input int th,
                          input logic [1:0] q, input int ex, input int ey, input int tol);
      int lat, bn;
      strobe(a, th, q);
      wait_vec(0, lat, bn);
      check({tag, "_lat"}, lat, 16, 0);
      check({tag, "_cx"}, sx(cx_out), ex, tol);
      check({tag, "_cy"}, sx(cy_out), ey, tol);
      idle(2);
   endtask

   initial begin
      int lat, bn, vv0, ov0;
      rst            = 1'b1;
      amp_in         = '0;
      theta_1st_quad = '0;
      quadrant       = '0;
      angle_valid    = 1'b0;
      idle(3);
      check("rst_cx", sx(cx_out), 0, 0);
      check("rst_cy", sx(cy_out), 0, 0);
      check("rst_vv", int'(vec_valid), 0, 0);
      check("rst_busy", int'(busy), 0, 0);
      check("rst_ov", int'(overrun), 0, 0);
      rst = 1'b0;
      idle(2);
      check("idle_busy", int'(busy), 0, 0);

      // basic conversion with latency and busy-length checks
      strobe(16'd16384, 0, 2'd0);
      wait_vec(0, lat, bn);
      check("q0_lat", lat, 16, 0);
      check("q0_busy_cycles", bn, 16, 0);
      check("q0_cx", sx(cx_out), 16384, 4);
      check("q0_cy", sx(cy_out), 0, 4);
      @(negedge clk);
      check("q0_vv_one_cycle", int'(vec_valid), 0, 0);
      check("q0_busy_done", int'(busy), 0, 0);
      check("q0_hold_cx", sx(cx_out), 16384, 4);
      idle(2);

      convert("q1_45", 16'd20000, 12868, 2'd1, -14142, 14142, 4);
      convert("q3_45", 16'd20000, 12868, 2'd3, 14142, -14142, 4);
      convert("q2_sat", 16'd32767, 25736, 2'd2, 0, -32767, 4);
      check("q2_sat_floor", int'(sx(cy_out) >= -32767), 1, 0);
      convert("clamp_hi", 16'd32767, 30000, 2'd0, 0, 32767, 4);
      convert("clamp_neg", 16'd20000, -500, 2'd0, 20000, 0, 4);
      convert("amp_msb", 16'hC000, 0, 2'd0, 16384, 0, 4);

      // overrun: second strobe 5 edges after the first is dropped
      #1;
      vv0 = vv_cnt;
      ov0 = ov_cnt;
      @(negedge clk);
      strobe(16'd16384, 0, 2'd0);
      idle(4);
      amp_in         = 16'd20000;
      theta_1st_quad = 17'd12868;
      quadrant       = 2'd1;
      angle_valid    = 1'b1;
      @(negedge clk);
      angle_valid = 1'b0;
      check("ovr_pulse", int'(overrun), 1, 0);
      @(negedge clk);
      check("ovr_one_cycle", int'(overrun), 0, 0);
      wait_vec(6, lat, bn);
      check("ovr_lat", lat, 16, 0);
      check("ovr_cx", sx(cx_out), 16384, 4);
      check("ovr_cy", sx(cy_out), 0, 4);

      // strobe in the vec_valid cycle is accepted
      strobe(16'd20000, 12868, 2'd3);
      check("b2b_no_ovr", int'(overrun), 0, 0);
      wait_vec(0, lat, bn);
      check("b2b_lat", lat, 16, 0);
      check("b2b_cx", sx(cx_out), 14142, 4);
      check("b2b_cy", sx(cy_out), -14142, 4);
      idle(20);
      #1;
      check("ovr_vv_count", vv_cnt - vv0, 2, 0);
      check("ovr_ov_count", ov_cnt - ov0, 1, 0);

      // reset in the middle of the rotations
      vv0 = vv_cnt;
      @(negedge clk);
      strobe(16'd20000, 12868, 2'd0);
      idle(8);
      rst = 1'b1;
      #1;
      check("midrst_cx", sx(cx_out), 0, 0);
      check("midrst_cy", sx(cy_out), 0, 0);
      check("midrst_vv", int'(vec_valid), 0, 0);
      check("midrst_busy", int'(busy), 0, 0);
      check("midrst_ov", int'(overrun), 0, 0);
      idle(2);
      rst = 1'b0;
      idle(30);
      #1;
      check("midrst_no_vv", vv_cnt - vv0, 0, 0);
      @(negedge clk);
      convert("after_rst", 16'd16384, 0, 2'd0, 16384, 0, 4);

      // zero amplitude in every quadrant
      for (int q = 0; q < 4; q++) begin
         convert($sformatf("amp0_q%0d", q), 16'd0, 6000, 2'(q), 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cordic_vector_synth.md
Name: cordic_vector_synth

Overview:
- Inverse of the angle-calculation path. Takes a first-quadrant angle, a quadrant code and an amplitude, and regenerates the signed Cartesian pair (cx, cy) = amp·(cos θ, sin θ).
- Uses an iterative rotation-mode CORDIC with a start/valid handshake.
- Used to synthesise reference CX/CY stimulus from computed angles and to loop-back-check the angle path in hardware.

Parameters:
- ITER, 14, number of CORDIC micro-rotations (valid range 8..14).
- IW, 20, internal signed datapath width for x/y.
- KGAIN, 39797, CORDIC gain compensation 0.607253 in Q0.16.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset, asynchronous, active-high.
- amp_in  input  16  unsigned amplitude; only 0..32767 is legal; bit 15 is ignored (treated as 0).
- theta_1st_quad  input  17  signed angle, radians Q3.14; legal range 0..25736 (π/2).
- quadrant  input  2  quadrant code: 0 = (+x,+y), 1 = (−x,+y), 2 = (−x,−y), 3 = (+x,−y).
- angle_valid  input  1  one-cycle strobe; inputs are qualified on this strobe.
- cx_out  output  16  signed synthesised X.
- cy_out  output  16  signed synthesised Y.
- vec_valid  output  1  one-cycle pulse; cx_out/cy_out are new.
- busy  output  1  high while a conversion is in progress.
- overrun  output  1  one-cycle pulse; angle_valid arrived while busy and was dropped.

Behaviour:
- Reset (async, rst = 1):
  - FSM returns to IDLE.
  - cx_out, cy_out, vec_valid, busy, overrun are all 0; internal x/y/z and iteration counter are 0.
  - Reset mid-conversion aborts it; no vec_valid follows.
- FSM states: IDLE → SCALE → ROT → MAP → IDLE. busy = (state != IDLE).
- IDLE:
  - On angle_valid = 1 at edge N, latch amp_in[14:0], theta and quadrant; go to SCALE.
  - Theta clamp: theta < 0 → 0; theta > 25736 → 25736.
- SCALE (edge N+1):
  - x ← (amp · KGAIN) >> 16, truncated, sign-extended to IW.
  - y ← 0; z ← clamped theta; counter i ← 0; go to ROT.
- ROT (edges N+2 .. N+1+ITER), one micro-rotation per clock:
  - If z ≥ 0: x ← x − (y >>> i); y ← y + (x >>> i); z ← z − atan[i].
  - Else: the opposite signs on all three updates.
  - Shifts are arithmetic; all updates use the old x/y.
  - atan table (Q3.14): 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2.
  - i increments each cycle; on the cycle i = ITER−1, go to MAP.
- MAP (edge N+2+ITER):
  - Quadrant mapping: q0: (x, y); q1: (−y, x); q2: (−x, −y); q3: (y, −x).
  - Saturate each result to [−32767, +32767], register into cx_out/cy_out, set vec_valid = 1, go to IDLE.
- Latency and throughput:
  - Latency from the angle_valid sampling edge to vec_valid high is ITER+2 clocks (16 at default).
  - vec_valid is high for exactly one cycle; cx_out/cy_out hold their value until the next MAP.
- Back-to-back:
  - angle_valid in the same cycle vec_valid is high is accepted, since the state is already IDLE.
  - Maximum rate is one conversion per ITER+3 clocks.
- Overrun:
  - angle_valid while busy: inputs are ignored and overrun pulses for one cycle (edge after).
  - The conversion in flight is unaffected.
- Accuracy: |error| ≤ 4 LSB per axis for legal inputs at ITER = 14.
- amp_in = 0 gives cx_out = cy_out = 0 for every angle and quadrant.

Test Plan:
- Reset release; amp = 16384, theta = 0, q = 0, one strobe → vec_valid exactly 16 clocks after the strobe edge; cx_out = 16384±4, cy_out = 0±4; busy high for 16 cycles.
- amp = 20000, theta = 12868 (π/4), q = 1 → cx_out = −14142±4, cy_out = +14142±4; repeat with q = 3 → cx_out = +14142±4, cy_out = −14142±4.
- amp = 32767, theta = 25736, q = 2 → cx_out = 0±4, cy_out = −32767 (saturation, no wrap); theta = 30000, q = 0 → same magnitude as theta = 25736 (clamp).
- Second strobe 5 cycles after the first → overrun pulses once; only one vec_valid; results match the first input. Strobe coincident with vec_valid → accepted, second vec_valid 16 clocks later.
- Assert rst during ROT (cycle 8) → all outputs 0 immediately; no vec_valid after release; next strobe converts normally.
- amp = 0, all four quadrants, theta = 6000 → cx_out = cy_out = 0 each time.
